// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and fills IF/ID.
// Define IF_STATS_EN to add the fetch_cnt / discard_cnt statistics ports.
package if_stage_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic        valid;
    } if_id_reg_t;
endpackage

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output if_id_reg_t  if_id_reg
`ifdef IF_STATS_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] discard_cnt
`endif
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    if_id_reg_t  if_id_q, if_id_d;
    logic        load;
    logic [31:0] load_word;
    logic [31:0] pc_plus4;

    assign pc_plus4   = pc_q + 32'd4;
    assign imem_addr  = pc_q;
    // Gate with rst so no request is visible while the block is held in reset.
    assign imem_rmask = (rst && state_q == StReq) ? 4'hF : 4'h0;
    assign if_id_reg  = if_id_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        if_id_d   = if_id_q;
        load      = 1'b0;
        load_word = imem_rdata;
        if (flush) begin
            pc_d          = redirect_pc;
            if_id_d.valid = 1'b0;
            unique case (state_q)
                StReq:             state_d = StDiscard;
                StWait, StDiscard: state_d = imem_resp ? StReq : StDiscard;
                StHold:            state_d = StReq;
                default:           state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: state_d = StWait;
                StWait: begin
                    if (imem_resp) begin
                        if (stall) begin
                            buf_d   = imem_rdata;
                            state_d = StHold;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        load      = 1'b1;
                        load_word = buf_q;
                    end
                end
                StDiscard: if (imem_resp) state_d = StReq;
                default:   state_d = StReq;
            endcase
            if (load) begin
                if_id_d.pc      = pc_q;
                if_id_d.pc_next = pc_plus4;
                if_id_d.inst    = load_word;
                if_id_d.valid   = 1'b1;
                pc_d            = pc_plus4;
                state_d         = StReq;
            end else if (!stall) begin
                // Decode must not see the same word twice: insert a bubble.
                if_id_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            if_id_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            if_id_q <= if_id_d;
        end
    end

`ifdef IF_STATS_EN
    logic drop;
    assign drop = imem_resp && (state_q == StDiscard || (state_q == StWait && flush));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt   <= '0;
            discard_cnt <= '0;
        end else begin
            if (load) fetch_cnt <= fetch_cnt + 32'd1;
            if (drop) discard_cnt <= discard_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage; first stage of the five-stage rv32i pipeline, directly upstream of the decode stage.
- Owns the PC and issues single-word reads to instruction memory.
- Captures each returned word into the IF/ID pipeline register, honouring stalls from the hazard unit and flush/redirects from the branch-resolution stage.
- Tracks one outstanding imem request and discards responses made stale by a flush.

Parameters:
RESET_PC, 32'h1ECEB000, PC value loaded on reset.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = in reset)
stall  input  1  hold IF/ID register and PC; from hazard unit
flush  input  1  redirect fetch; from EX branch/jump resolution
redirect_pc  input  32  new fetch address, valid when flush=1
imem_addr  output  32  fetch address; equals pc
imem_rmask  output  4  4'hF for exactly one cycle per request, else 4'h0
imem_rdata  input  32  instruction word, valid when imem_resp=1
imem_resp  input  1  one-cycle response strobe for the outstanding request
if_id_reg  output  if_id_reg_t  fields: pc[31:0], pc_next[31:0], inst[31:0], valid

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; state=REQ; buf=0.
  - if_id_reg: all fields 0, valid=0.
  - imem_rmask=0 while in reset.
- States: REQ, WAIT, HOLD, DISCARD. All outputs are registered except imem_addr and imem_rmask, which are combinational from pc and state.
- REQ:
  - imem_rmask=4'hF, imem_addr=pc; next state WAIT.
  - REQ lasts one cycle.
  - The first request is issued in the first cycle after rst deasserts.
- WAIT:
  - imem_rmask=0.
  - No imem_resp: stay in WAIT.
  - imem_resp and stall=0: load if_id_reg with pc=pc, pc_next=pc+4, inst=imem_rdata, valid=1. Then pc<=pc+4; next state REQ.
  - imem_resp and stall=1: buf<=imem_rdata; next state HOLD.
- HOLD:
  - imem_rmask=0.
  - When stall=0: if_id_reg<={pc, pc+4, buf, 1}; pc<=pc+4; next state REQ.
- DISCARD:
  - imem_rmask=0.
  - On imem_resp: drop the data, update nothing; next state REQ.
- IF/ID register holds:
  - While stall=1 and flush=0, if_id_reg holds its value in every state.
  - In WAIT with stall=0 and no imem_resp, if_id_reg.valid<=0 (bubble). pc, pc_next and inst keep their old values.
- Flush (highest priority; overrides stall):
  - pc<=redirect_pc; if_id_reg.valid<=0; buf content is dead.
  - From REQ: the request issued this cycle is outstanding, so next state DISCARD.
  - From WAIT with no imem_resp this cycle: next state DISCARD.
  - From WAIT with imem_resp this cycle: drop the response; next state REQ.
  - From HOLD: next state REQ.
  - From DISCARD with no imem_resp: pc updates, stay in DISCARD.
  - From DISCARD with imem_resp: pc updates, next state REQ.
- Arithmetic and widths:
  - pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
  - redirect_pc is taken as given; bits [1:0] are not masked.
- Outstanding requests:
  - Never more than one outstanding request.
  - imem_resp arriving in REQ or HOLD is a protocol violation; ignore it (assertion in bench).
- Reset mid-operation: an outstanding request is abandoned. The memory model must be reset together with the block.

Optional Feature:
- Macro: IF_STATS_EN.
- Defined:
  - Adds output ports fetch_cnt[31:0] and discard_cnt[31:0], both reset to 0.
  - fetch_cnt increments on every cycle with if_id_reg.valid loaded to 1.
  - discard_cnt increments on every dropped response (DISCARD resp, or WAIT resp coincident with flush).
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle memory (1-cycle resp, stall=0, flush=0):
  - imem_addr sequence 1ECEB000, 1ECEB004, 1ECEB008.
  - Each if_id_reg.valid=1 with pc matching and pc_next=pc+4.
  - One instruction every 2 cycles.
- Stall held 3 cycles across imem_resp with rdata=32'h00A00093:
  - if_id_reg unchanged during the stall.
  - One cycle after stall falls: inst=00A00093, valid=1.
  - No new request before that.
- Flush with redirect_pc=32'h1ECEB100 while in WAIT, resp 2 cycles later with rdata=32'hDEADBEEF:
  - Stale word never reaches if_id_reg (valid stays 0).
  - Next imem_addr=1ECEB100.
- Flush coincident with imem_resp in WAIT, and flush concurrent with stall=1:
  - Response dropped; valid=0.
  - Next request goes to redirect_pc with no DISCARD cycle.
- Async reset (rst=0) asserted mid-WAIT, between clock edges:
  - Outputs immediately: valid=0, imem_rmask=0.
  - After release, first imem_addr=RESET_PC.
- PC wrap with RESET_PC=32'hFFFFFFFC:
  - Second fetch address is 32'h00000000.
  - With IF_STATS_EN, fetch_cnt=2 and discard_cnt=0.
